// File: rtl/int_pkg.sv
// Shared types and helpers for the nested-priority interrupt controller.
package int_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam int MAX_CH = 32;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Highest-set-bit encoder: valid flag plus index of the top set bit.
// Latency: combinational.
// Backpressure: none, pure function of the input vector.
module prio_enc
    import int_pkg::*;
#(
    parameter int N = 3,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  vec,
    output logic          vld,
    output logic [IW-1:0] idx
);

    always_comb begin
        vld = 1'b0;
        idx = '0;
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < N && i < MAX_CH; i++) begin
            if (vec[i]) begin
                vld = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Nested-priority interrupt controller: latches requests, presents the best unmasked channel.
// Latency: request edge to int_req is two cycles when no higher level is in service.
// Backpressure: int_req/int_id hold until int_ack, or withdraw on disable or mask.
module int_ctrl
    import int_pkg::*;
#(
    parameter int N    = 3,
    parameter int EDGE = 1,
    localparam int IW  = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  irq_in,
    input  logic [N-1:0]  irq_mask,
    input  logic          int_en,
    input  logic          int_ack,
    input  logic          int_ret,
    output logic          int_req,
    output logic [IW-1:0] int_id,
    output logic [N-1:0]  ir,
    output logic [N-1:0]  irs
);

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    irq_q;
    logic [N-1:0]    cap;
    logic [N-1:0]    above;
    logic [N-1:0]    cand_vec;
    logic            cand_vld;
    logic [IW-1:0]   cand_idx;
    logic            top_vld;
    logic [IW-1:0]   top_idx;
    logic            elig;
    logic            ack_take;
    logic [N-1:0]    id_oh;
    logic [N-1:0]    top_oh;
    logic [N-1:0]    ir_nxt;
    logic [N-1:0]    irs_nxt;

    assign cap = (EDGE != 0) ? (irq_in & ~irq_q) : irq_in;

    prio_enc #(.N(N)) u_top (
        .vec (irs),
        .vld (top_vld),
        .idx (top_idx)
    );

    // Only channels strictly above the current in-service level may preempt.
    always_comb begin
        above = '0;
        for (int i = 0; i < N; i++) begin
            above[i] = !top_vld || (IW'(i) > top_idx);
        end
    end

    assign cand_vec = ir & ~irq_mask & above;

    prio_enc #(.N(N)) u_cand (
        .vec (cand_vec),
        .vld (cand_vld),
        .idx (cand_idx)
    );

    assign elig     = cand_vld && int_en;
    assign ack_take = (state == REQ) && int_ack;
    assign id_oh    = N'(1) << int_id;
    assign top_oh   = N'(1) << top_idx;

    // Clear-then-set ordering lets a same-cycle capture re-pend the acked channel.
    assign ir_nxt  = (ir & ~(ack_take ? id_oh : '0)) | cap;
    assign irs_nxt = (irs & ~((int_ret && top_vld) ? top_oh : '0)) | (ack_take ? id_oh : '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (elig) state_nxt = REQ;
            REQ: begin
                if (int_ack) begin
                    state_nxt = IDLE;
                end else if (!int_en || irq_mask[int_id]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            int_id <= '0;
            irq_q  <= '0;
            ir     <= '0;
            irs    <= '0;
        end else begin
            state <= state_nxt;
            irq_q <= irq_in;
            ir    <= ir_nxt;
            irs   <= irs_nxt;
            if (state == IDLE && elig) begin
                int_id <= cand_idx;
            end
        end
    end

    assign int_req = (state == REQ);

endmodule

// File: tb/tb_int_ctrl.sv
// Directed vector bench for int_ctrl: N=3 edge-latched table plus an N=8 level-mode sequence.
module tb_int_ctrl;

    logic       clk;
    logic       rst_n;

    logic [2:0] irq_in, irq_mask, ir, irs;
    logic       int_en, int_ack, int_ret, int_req;
    logic [1:0] int_id;

    logic [7:0] irq_in8, irq_mask8, ir8, irs8;
    logic       int_en8, int_ack8, int_ret8, int_req8;
    logic [2:0] int_id8;

    int total;
    int passed;

    int_ctrl #(.N(3), .EDGE(1)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_in   (irq_in),
        .irq_mask (irq_mask),
        .int_en   (int_en),
        .int_ack  (int_ack),
        .int_ret  (int_ret),
        .int_req  (int_req),
        .int_id   (int_id),
        .ir       (ir),
        .irs      (irs)
    );

    int_ctrl #(.N(8), .EDGE(0)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_in   (irq_in8),
        .irq_mask (irq_mask8),
        .int_en   (int_en8),
        .int_ack  (int_ack8),
        .int_ret  (int_ret8),
        .int_req  (int_req8),
        .int_id   (int_id8),
        .ir       (ir8),
        .irs      (irs8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] irq;
        logic [2:0] mask;
        logic       en;
        logic       ack;
        logic       ret;
        logic       req;
        logic [1:0] id;
        logic [2:0] ir;
        logic [2:0] irs;
    } vec_t;

    vec_t tv[32];

    function automatic vec_t mk(input logic [2:0] irq, input logic [2:0] mask, input logic en,
                                input logic ack, input logic ret, input logic req,
                                input logic [1:0] id, input logic [2:0] ir_e, input logic [2:0] irs_e);
        vec_t v;
        v.irq = irq; v.mask = mask; v.en = en; v.ack = ack; v.ret = ret;
        v.req = req; v.id = id; v.ir = ir_e; v.irs = irs_e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        bit found;
        total   = 0;
        passed  = 0;
        rst_n   = 1'b0;
        irq_in  = '0; irq_mask = '0; int_en = 1'b1; int_ack = 1'b0; int_ret = 1'b0;
        irq_in8 = '0; irq_mask8 = '0; int_en8 = 1'b1; int_ack8 = 1'b0; int_ret8 = 1'b0;

        //           irq     mask    en  ack ret  req id  ir      irs
        tv[0]  = mk(3'b001, 3'b000, 1, 0, 0,   0, 0, 3'b001, 3'b000);
        tv[1]  = mk(3'b000, 3'b000, 1, 0, 0,   1, 0, 3'b001, 3'b000);
        tv[2]  = mk(3'b000, 3'b000, 1, 1, 0,   0, 0, 3'b000, 3'b001);
        tv[3]  = mk(3'b100, 3'b000, 1, 0, 0,   0, 0, 3'b100, 3'b001);
        tv[4]  = mk(3'b100, 3'b000, 1, 0, 0,   1, 2, 3'b100, 3'b001);
        tv[5]  = mk(3'b000, 3'b000, 1, 1, 0,   0, 0, 3'b000, 3'b101);
        tv[6]  = mk(3'b000, 3'b000, 1, 0, 1,   0, 0, 3'b000, 3'b001);
        tv[7]  = mk(3'b000, 3'b000, 1, 0, 1,   0, 0, 3'b000, 3'b000);
        tv[8]  = mk(3'b100, 3'b000, 1, 0, 0,   0, 0, 3'b100, 3'b000);
        tv[9]  = mk(3'b000, 3'b000, 1, 0, 0,   1, 2, 3'b100, 3'b000);
        tv[10] = mk(3'b000, 3'b000, 1, 1, 0,   0, 0, 3'b000, 3'b100);
        tv[11] = mk(3'b010, 3'b000, 1, 0, 0,   0, 0, 3'b010, 3'b100);
        tv[12] = mk(3'b000, 3'b000, 1, 0, 0,   0, 0, 3'b010, 3'b100);
        tv[13] = mk(3'b000, 3'b000, 1, 0, 1,   0, 0, 3'b010, 3'b000);
        tv[14] = mk(3'b000, 3'b000, 1, 0, 0,   1, 1, 3'b010, 3'b000);
        tv[15] = mk(3'b000, 3'b000, 1, 1, 0,   0, 0, 3'b000, 3'b010);
        tv[16] = mk(3'b100, 3'b000, 1, 0, 0,   0, 0, 3'b100, 3'b010);
        tv[17] = mk(3'b000, 3'b000, 1, 0, 0,   1, 2, 3'b100, 3'b010);
        tv[18] = mk(3'b000, 3'b100, 1, 0, 0,   0, 0, 3'b100, 3'b010);
        tv[19] = mk(3'b000, 3'b100, 1, 0, 0,   0, 0, 3'b100, 3'b010);
        tv[20] = mk(3'b000, 3'b000, 1, 0, 0,   1, 2, 3'b100, 3'b010);
        tv[21] = mk(3'b000, 3'b000, 1, 1, 1,   0, 0, 3'b000, 3'b100);
        tv[22] = mk(3'b000, 3'b000, 1, 0, 1,   0, 0, 3'b000, 3'b000);
        tv[23] = mk(3'b000, 3'b000, 1, 0, 1,   0, 0, 3'b000, 3'b000);
        tv[24] = mk(3'b000, 3'b000, 1, 1, 0,   0, 0, 3'b000, 3'b000);
        tv[25] = mk(3'b001, 3'b000, 1, 0, 0,   0, 0, 3'b001, 3'b000);
        tv[26] = mk(3'b000, 3'b000, 1, 0, 0,   1, 0, 3'b001, 3'b000);
        tv[27] = mk(3'b100, 3'b000, 1, 0, 0,   1, 0, 3'b101, 3'b000);
        tv[28] = mk(3'b000, 3'b000, 0, 0, 0,   0, 0, 3'b101, 3'b000);
        tv[29] = mk(3'b000, 3'b000, 1, 0, 0,   1, 2, 3'b101, 3'b000);
        tv[30] = mk(3'b100, 3'b000, 1, 1, 0,   0, 0, 3'b101, 3'b100);
        tv[31] = mk(3'b000, 3'b000, 1, 0, 0,   0, 0, 3'b101, 3'b100);

        #3;
        check("rst_req", 32'(int_req), 32'd0);
        check("rst_id",  32'(int_id),  32'd0);
        check("rst_ir",  32'(ir),      32'd0);
        check("rst_irs", 32'(irs),     32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            irq_in   = tv[k].irq;
            irq_mask = tv[k].mask;
            int_en   = tv[k].en;
            int_ack  = tv[k].ack;
            int_ret  = tv[k].ret;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_req", k), 32'(int_req), 32'(tv[k].req));
            if (tv[k].req) check($sformatf("v%0d_id", k), 32'(int_id), 32'(tv[k].id));
            check($sformatf("v%0d_ir", k),  32'(ir),  32'(tv[k].ir));
            check($sformatf("v%0d_irs", k), 32'(irs), 32'(tv[k].irs));
        end

        @(negedge clk);
        irq_in = '0; int_ack = 1'b0; int_ret = 1'b0; int_en = 1'b1; irq_mask = '0;

        // Level mode: a request held across its own ack stays pending.
        irq_in8 = 8'h20;
        @(posedge clk); #1;
        check("l_ir_set", 32'(ir8), 32'h20);
        check("l_noreq",  32'(int_req8), 32'd0);
        @(posedge clk); #1;
        check("l_req", 32'(int_req8), 32'd1);
        check("l_id",  32'(int_id8),  32'd5);
        @(negedge clk); int_ack8 = 1'b1;
        @(posedge clk); #1;
        check("l_ack_req", 32'(int_req8), 32'd0);
        check("l_ack_irs", 32'(irs8), 32'h20);
        check("l_repend",  32'(ir8),  32'h20);
        @(negedge clk); int_ack8 = 1'b0;
        @(posedge clk); #1;
        check("l_self_block", 32'(int_req8), 32'd0);
        @(negedge clk); int_ret8 = 1'b1;
        @(posedge clk); #1;
        check("l_ret_irs", 32'(irs8), 32'h00);
        @(negedge clk); int_ret8 = 1'b0;

        found = 1'b0;
        for (int c = 0; c < 4 && !found; c++) begin
            @(posedge clk); #1;
            if (int_req8) found = 1'b1;
        end
        check("l_rereq_seen", 32'(found), 32'd1);
        check("l_rereq_id",   32'(int_id8), 32'd5);

        // Asynchronous reset in the middle of a presented request.
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req8", 32'(int_req8), 32'd0);
        check("ar_id8",  32'(int_id8),  32'd0);
        check("ar_ir8",  32'(ir8),      32'd0);
        check("ar_irs8", 32'(irs8),     32'd0);
        check("ar_ir3",  32'(ir),       32'd0);
        check("ar_irs3", 32'(irs),      32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
